// File: rtl/count_fsm.sv
// Start-triggered up-counter FSM: counts until flag, holds the count for a
// programmable number of wait cycles, then returns to idle.
module count_fsm #(
    parameter int CNT_W = 8,
    parameter int TMR_W = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             flag,
    input  logic [TMR_W-1:0] wait_timer,
    output logic             busy,
    output logic [CNT_W-1:0] count_value
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        WAIT  = 2'd2
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] count_next;
    logic [TMR_W-1:0] timer;
    logic [TMR_W-1:0] timer_next;

    // rst_n is active-high despite its name
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state       <= IDLE;
            count_value <= '0;
            timer       <= '0;
        end else begin
            state       <= state_next;
            count_value <= count_next;
            timer       <= timer_next;
        end
    end

    always_comb begin
        state_next = state;
        count_next = count_value;
        timer_next = timer;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = COUNT;
                    count_next = '0;
                end
            end
            COUNT: begin
                if (flag) begin
                    if (wait_timer != '0) begin
                        state_next = WAIT;
                        timer_next = wait_timer;
                    end else begin
                        state_next = IDLE;
                    end
                end else begin
                    count_next = count_value + 1'b1;
                end
            end
            WAIT: begin
                // leaving on timer==1 makes WAIT last exactly wait_timer cycles
                if (timer <= TMR_W'(1)) begin
                    state_next = IDLE;
                end else begin
                    timer_next = timer - 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_count_fsm.sv
// Self-checking bench for count_fsm: directed vector table, wrap-around
// sequence, and randomized run against a cycle-level behavioural model.
module tb_count_fsm;

    localparam int CNT_W = 8;
    localparam int TMR_W = 4;

    logic             clk;
    logic             rst_n;
    logic             start;
    logic             flag;
    logic [TMR_W-1:0] wait_timer;
    logic             busy;
    logic [CNT_W-1:0] count_value;

    int checks = 0;
    int errors = 0;

    // behavioural model: activity flag, counting phase, remaining hold cycles
    bit          m_active;
    bit          m_counting;
    int          m_hold;
    int unsigned m_cnt;

    count_fsm #(.CNT_W(CNT_W), .TMR_W(TMR_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (start),
        .flag       (flag),
        .wait_timer (wait_timer),
        .busy       (busy),
        .count_value(count_value)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit          rst;
        bit          st;
        bit          fl;
        int unsigned wt;
        bit          exp_busy;
        int unsigned exp_cnt;
    } vec_t;

    task automatic check(input string name, input int unsigned got, input int unsigned exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    task automatic model_update();
        if (rst_n) begin
            m_active = 0; m_counting = 0; m_hold = 0; m_cnt = 0;
        end else if (!m_active) begin
            if (start) begin
                m_active = 1; m_counting = 1; m_cnt = 0;
            end
        end else if (m_counting) begin
            if (flag) begin
                m_counting = 0;
                if (wait_timer == 0) m_active = 0;
                else m_hold = int'(wait_timer);
            end else begin
                m_cnt = (m_cnt + 1) % (1 << CNT_W);
            end
        end else begin
            m_hold = m_hold - 1;
            if (m_hold == 0) m_active = 0;
        end
    endtask

    // one clock edge with the current inputs; outputs sampled 1 time unit later
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic drive(input bit r, input bit s, input bit f, input int unsigned w);
        rst_n      = r;
        start      = s;
        flag       = f;
        wait_timer = TMR_W'(w);
    endtask

    vec_t vecs[$];

    initial begin
        drive(1, 1, 1, 0);
        // reset with start/flag asserted
        vecs.push_back('{1, 1, 1, 0, 0, 0});
        vecs.push_back('{1, 1, 1, 0, 0, 0});
        // basic run: start at edge 0, flag at edge 6, wait 3
        vecs.push_back('{0, 1, 0, 3, 1, 0});
        vecs.push_back('{0, 0, 0, 3, 1, 1});
        vecs.push_back('{0, 1, 0, 3, 1, 2});   // start ignored in COUNT
        vecs.push_back('{0, 0, 0, 3, 1, 3});
        vecs.push_back('{0, 0, 0, 3, 1, 4});
        vecs.push_back('{0, 0, 0, 3, 1, 5});
        vecs.push_back('{0, 0, 1, 3, 1, 5});   // flag edge: hold
        vecs.push_back('{0, 1, 1, 0, 1, 5});   // start/flag/timer ignored in WAIT
        vecs.push_back('{0, 0, 0, 15, 1, 5});
        vecs.push_back('{0, 0, 0, 1, 0, 5});   // third wait edge: idle
        vecs.push_back('{0, 0, 1, 7, 0, 5});   // flag ignored in IDLE
        // start+flag in IDLE: start wins; then zero-wait flag
        vecs.push_back('{0, 1, 1, 0, 1, 0});
        vecs.push_back('{0, 0, 1, 0, 0, 0});
        // reset during COUNT at count 4
        vecs.push_back('{0, 1, 0, 0, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 1});
        vecs.push_back('{0, 0, 0, 0, 1, 2});
        vecs.push_back('{0, 0, 0, 0, 1, 3});
        vecs.push_back('{0, 0, 0, 0, 1, 4});
        vecs.push_back('{1, 1, 1, 0, 0, 0});
        // reset during WAIT
        vecs.push_back('{0, 1, 0, 0, 1, 0});
        vecs.push_back('{0, 0, 0, 0, 1, 1});
        vecs.push_back('{0, 0, 1, 5, 1, 1});
        vecs.push_back('{0, 0, 0, 5, 1, 1});
        vecs.push_back('{1, 0, 0, 5, 0, 0});
        vecs.push_back('{0, 0, 0, 0, 0, 0});
        // start held high: one idle cycle between runs
        vecs.push_back('{0, 1, 1, 1, 1, 0});
        vecs.push_back('{0, 1, 1, 1, 1, 0});
        vecs.push_back('{0, 1, 0, 1, 0, 0});
        vecs.push_back('{0, 1, 0, 1, 1, 0});
        vecs.push_back('{0, 0, 1, 0, 0, 0});

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].st, vecs[i].fl, vecs[i].wt);
            step();
            check($sformatf("vec%0d_busy", i), 32'(busy), 32'(vecs[i].exp_busy));
            check($sformatf("vec%0d_count", i), 32'(count_value), vecs[i].exp_cnt);
        end

        // wrap-around: 257 increments from 0 ends at 1
        drive(0, 1, 0, 0);
        step();
        check("wrap_start_busy", 32'(busy), 1);
        drive(0, 0, 0, 0);
        for (int unsigned e = 1; e <= 257; e++) begin
            step();
            if (e == 255) check("wrap_max", 32'(count_value), 255);
            if (e == 256) check("wrap_zero", 32'(count_value), 0);
            if (e == 257) check("wrap_one", 32'(count_value), 1);
            if (busy !== 1'b1) check("wrap_busy", 32'(busy), 1);
        end
        drive(0, 0, 1, 0);
        step();
        check("wrap_final_count", 32'(count_value), 1);
        check("wrap_final_busy", 32'(busy), 0);

        // randomized stimulus against the model
        for (int n = 0; n < 4000; n++) begin
            drive(($urandom_range(0, 199) == 0),
                  ($urandom_range(0, 7) == 0),
                  ($urandom_range(0, 39) == 0),
                  $urandom_range(0, (1 << TMR_W) - 1));
            step();
            check("rand_busy", 32'(busy), 32'(m_active));
            check("rand_count", 32'(count_value), m_cnt);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
